// File: rtl/cambio_dispenser.sv
// ---------------------------------------------------------------------------
// cambio_dispenser
//
// Purpose:
//   Dispenses a change amount (0..15 units) as a sequence of coin ejects,
//   using the largest coin that still fits (5, then 2, then 1). Each eject is
//   a fixed-length pulse on the matching sale output, followed by a wait for
//   the hopper to acknowledge that the coin has physically left. A missing
//   acknowledge parks the block in an error state until borrar is asserted.
//
// Parameters:
//   PULSE_LEN    cycles each sale output is held high (>= 1)
//   TIMEOUT      cycles to wait for hopper_listo after a pulse (>= 1)
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous, active-low reset
//   cambio[3:0]  amount to dispense, captured on an accepted cargar
//   cargar       one-cycle load request, honoured only when idle
//   hopper_listo hopper acknowledge for the last ejected coin
//   borrar       leaves the error state
//   sale5/2/1    eject pulses for the 5-, 2- and 1-unit coins
//   ocupado      high whenever the block is not idle
//   hecho        one-cycle pulse once the whole amount has been dispensed
//   error        high while in the error state
//   faltante     amount still to be dispensed
//
// All outputs come straight from flops; nothing combinational reaches an
// output from an input.
// ---------------------------------------------------------------------------
module cambio_dispenser #(
    parameter int PULSE_LEN = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cambio,
    input  logic       cargar,
    input  logic       hopper_listo,
    input  logic       borrar,
    output logic       sale5,
    output logic       sale2,
    output logic       sale1,
    output logic       ocupado,
    output logic       hecho,
    output logic       error,
    output logic [3:0] faltante
);

    // Counter is shared by the pulse phase and the acknowledge wait, so it is
    // sized for whichever of the two is longer.
    localparam int CNT_MAX = (PULSE_LEN > TIMEOUT) ? PULSE_LEN : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SELECT   = 3'd1;
    localparam logic [2:0] ST_PULSE    = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;
    localparam logic [2:0] ST_ERROR    = 3'd5;

    localparam logic [1:0] COIN_1 = 2'd0;
    localparam logic [1:0] COIN_2 = 2'd1;
    localparam logic [1:0] COIN_5 = 2'd2;

    logic [2:0]       state, state_nxt;
    logic [3:0]       resto, resto_nxt;
    logic [1:0]       coin, coin_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;

    // Face value of the currently selected coin.
    function automatic logic [3:0] coin_value(input logic [1:0] c);
        case (c)
            COIN_5:  coin_value = 4'd5;
            COIN_2:  coin_value = 4'd2;
            default: coin_value = 4'd1;
        endcase
    endfunction

    // Saturating increment: the counter parks at its maximum instead of
    // wrapping, so a stuck wait can never masquerade as a fresh count.
    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CNT_ONE;

    // Next-state logic. The greedy coin choice is made once per coin in
    // SELECT and then held in 'coin' through PULSE and WAIT_ACK, so the
    // decrement always matches the coin that was actually ejected.
    always_comb begin
        state_nxt = state;
        resto_nxt = resto;
        coin_nxt  = coin;
        cnt_nxt   = cnt;

        case (state)
            ST_IDLE: begin
                if (cargar) begin
                    resto_nxt = cambio;
                    state_nxt = ST_SELECT;
                end
            end

            ST_SELECT: begin
                cnt_nxt = '0;
                if (resto == 4'd0) begin
                    state_nxt = ST_DONE;
                end else begin
                    if (resto >= 4'd5) begin
                        coin_nxt = COIN_5;
                    end else if (resto >= 4'd2) begin
                        coin_nxt = COIN_2;
                    end else begin
                        coin_nxt = COIN_1;
                    end
                    state_nxt = ST_PULSE;
                end
            end

            // hopper_listo is deliberately not looked at here: an early
            // acknowledge would refer to the previous coin.
            ST_PULSE: begin
                if (cnt == PULSE_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_WAIT_ACK;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end

            // The acknowledge is tested before the timeout, so an
            // acknowledge in the very last wait cycle still wins.
            ST_WAIT_ACK: begin
                if (hopper_listo) begin
                    resto_nxt = resto - coin_value(coin);
                    cnt_nxt   = '0;
                    state_nxt = ST_SELECT;
                end else if (cnt == TIMEOUT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_ERROR;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end

            ST_DONE: begin
                state_nxt = ST_IDLE;
            end

            ST_ERROR: begin
                if (borrar) begin
                    resto_nxt = 4'd0;
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                resto_nxt = 4'd0;
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers. Outputs are decoded from the next-state
    // values so they line up with the state they describe while still
    // being plain flops that reset clears immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            resto   <= 4'd0;
            coin    <= COIN_1;
            cnt     <= '0;
            sale5   <= 1'b0;
            sale2   <= 1'b0;
            sale1   <= 1'b0;
            ocupado <= 1'b0;
            hecho   <= 1'b0;
            error   <= 1'b0;
        end else begin
            state   <= state_nxt;
            resto   <= resto_nxt;
            coin    <= coin_nxt;
            cnt     <= cnt_nxt;
            sale5   <= (state_nxt == ST_PULSE) && (coin_nxt == COIN_5);
            sale2   <= (state_nxt == ST_PULSE) && (coin_nxt == COIN_2);
            sale1   <= (state_nxt == ST_PULSE) && (coin_nxt == COIN_1);
            ocupado <= (state_nxt != ST_IDLE);
            hecho   <= (state_nxt == ST_DONE);
            error   <= (state_nxt == ST_ERROR);
        end
    end

    // resto is itself a register, so exposing it directly keeps faltante
    // registered and always equal to the remaining amount.
    assign faltante = resto;

endmodule
